idli_uart_m: RTL and testbench

// - UART peripheral driven by the core's nibble-serial datapath; it drives the top-level

---
 rtl/idli_pkg.sv | 8 +
 rtl/idli_uart_fifo_m.sv | 37 +++
 rtl/idli_uart_m.sv | 118 +++++++++++
 tb/tb_idli_uart_m.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// idli_pkg: shared core datapath types plus the UART byte, state and baud constants
package idli_pkg;
  typedef logic [1:0] ctr_t;
  typedef logic [3:0] slice_t;
  typedef logic [7:0] uart_byte_t;
  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;
  localparam int UART_CLK_DIV = 16;
endpackage

// File: rtl/idli_uart_fifo_m.sv
// idli_uart_fifo_m: byte FIFO with wrap-bit pointers; pushes into a full FIFO are dropped
module idli_uart_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  uart_byte_t mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/idli_uart_m.sv
// idli_uart_m: 8N1 UART bridged to the nibble-serial core datapath, with TX and RX byte FIFOs
module idli_uart_m
  import idli_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_uart_gck,
  input  logic       i_top_rst_n,
  input  logic [1:0] i_uart_ctr,
  input  logic       i_uart_wr_en,
  input  logic       i_uart_rd_en,
  input  logic [3:0] i_uart_slice,
  output logic [3:0] o_uart_slice,
  output logic       o_uart_tx_full,
  output logic       o_uart_rx_vld,
  input  logic       i_uart_rx,
  output logic       o_uart_tx
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  logic wr_act, rd_act, tx_push, tx_pop, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  slice_t wr_lo, wr_hi;
  uart_byte_t tx_head, rx_head, tx_sh, rx_sh;
  uart_state_t tx_state, rx_state;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_idx, rx_idx;
  logic rx_m, rx_s, tx_tick, rx_tick;
  assign tx_push = wr_act && i_uart_ctr == 2'd3;
  assign rx_pop = rd_act && i_uart_ctr == 2'd3;
  assign tx_pop = tx_state == UART_IDLE && !tx_empty;
  assign tx_tick = tx_cnt == '0;
  assign rx_tick = rx_cnt == '0;
  assign rx_push = rx_state == UART_STOP && rx_tick && rx_s && !rx_full;
  assign o_uart_rx_vld = !rx_empty;
  assign o_uart_tx = tx_state == UART_START ? 1'b0 : tx_state == UART_DATA ? tx_sh[0] : 1'b1;
  // The low slice is driven straight from the FIFO head in the same cycle the read is requested
  assign o_uart_slice = (i_uart_ctr == 2'd0 && i_uart_rd_en && !rx_empty) ? rx_head[3:0] :
                        (i_uart_ctr == 2'd1 && rd_act) ? rx_head[7:4] : 4'h0;
  idli_uart_fifo_m #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(i_uart_gck), .rst_n(i_top_rst_n), .push(tx_push), .pop(tx_pop),
    .din({wr_hi, wr_lo}), .dout(tx_head), .full(o_uart_tx_full), .empty(tx_empty)
  );
  idli_uart_fifo_m #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(i_uart_gck), .rst_n(i_top_rst_n), .push(rx_push), .pop(rx_pop),
    .din(rx_sh), .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );
  always_ff @(posedge i_uart_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      wr_act <= 1'b0;
      rd_act <= 1'b0;
      wr_lo <= '0;
      wr_hi <= '0;
    end else begin
      wr_act <= (i_uart_ctr == 2'd0) ? i_uart_wr_en : (i_uart_ctr == 2'd3) ? 1'b0 : wr_act;
      rd_act <= (i_uart_ctr == 2'd0) ? (i_uart_rd_en && !rx_empty) : (i_uart_ctr == 2'd3) ? 1'b0 : rd_act;
      if (i_uart_ctr == 2'd0 && i_uart_wr_en) wr_lo <= i_uart_slice;
      if (i_uart_ctr == 2'd1 && wr_act) wr_hi <= i_uart_slice;
    end
  end
  always_ff @(posedge i_uart_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      tx_state <= UART_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
    end else begin
      if (tx_state != UART_IDLE) tx_cnt <= tx_tick ? BIT_LAST : tx_cnt - 1'b1;
      case (tx_state)
        UART_IDLE: if (!tx_empty) begin
          tx_state <= UART_START;
          tx_cnt <= BIT_LAST;
          tx_idx <= '0;
          tx_sh <= tx_head;
        end
        UART_START: if (tx_tick) tx_state <= UART_DATA;
        UART_DATA: if (tx_tick) begin
          tx_sh <= tx_sh >> 1;
          tx_idx <= tx_idx + 1'b1;
          if (tx_idx == 3'd7) tx_state <= UART_STOP;
        end
        default: if (tx_tick) tx_state <= UART_IDLE;
      endcase
    end
  end
  // Receiver samples mid-bit: half a bit after the falling edge, then every full bit
  always_ff @(posedge i_uart_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_state <= UART_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
      if (rx_state != UART_IDLE) rx_cnt <= rx_tick ? BIT_LAST : rx_cnt - 1'b1;
      case (rx_state)
        UART_IDLE: if (!rx_s) begin
          rx_state <= UART_START;
          rx_cnt <= HALF_LAST;
        end
        UART_START: if (rx_tick) begin
          rx_state <= rx_s ? UART_IDLE : UART_DATA;
          rx_idx <= '0;
        end
        UART_DATA: if (rx_tick) begin
          rx_sh <= {rx_s, rx_sh[7:1]};
          rx_idx <= rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_state <= UART_STOP;
        end
        default: if (rx_tick) rx_state <= UART_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_idli_uart_m.sv
// tb_idli_uart_m: queue-level UART model checked every cycle, plus directed literal checks
module tb_idli_uart_m;
  localparam int CD = 16;
  localparam int H = CD / 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CD + 1;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, loop = 1'b0, rx_drv = 1'b1;
  logic [1:0] ctr = 2'd0;
  logic [3:0] slice_in = 4'h0, slice_out;
  logic tx_full, rx_vld, tx, rx;
  int checks = 0, errors = 0;
  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  idli_uart_m #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .i_uart_gck(clk), .i_top_rst_n(rst_n), .i_uart_ctr(ctr), .i_uart_wr_en(wr_en),
    .i_uart_rd_en(rd_en), .i_uart_slice(slice_in), .o_uart_slice(slice_out),
    .o_uart_tx_full(tx_full), .o_uart_rx_vld(rx_vld), .i_uart_rx(rx), .o_uart_tx(tx)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: byte queues, a frame timer for the line, and sample instants counted from the start edge
  logic [7:0] txq[$], rxq[$];
  int m_t = 0, r_c = 0, k;
  logic [9:0] m_frame = '1;
  logic wact = 1'b0, ract = 1'b0, m_s1 = 1'b1, m_s2 = 1'b1, r_act = 1'b0, line_n = 1'b1;
  logic txf, rxf, rxpush;
  logic [3:0] wlo = 4'h0, whi = 4'h0;
  logic [7:0] r_byte = 8'h00;
  always @(negedge clk) line_n = rx;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txq.delete(); rxq.delete();
      m_t = 0; wact = 1'b0; ract = 1'b0; m_s1 = 1'b1; m_s2 = 1'b1; r_act = 1'b0; r_c = 0;
    end else begin
      txf = txq.size() == DEPTH;
      rxf = rxq.size() == DEPTH;
      if (m_t > 0) m_t--;
      else if (txq.size() > 0) begin
        m_frame = {1'b1, txq.pop_front(), 1'b0};
        m_t = 10 * CD;
      end
      if (wact && ctr == 2'd3) begin
        if (!txf) txq.push_back({whi, wlo});
        wact = 1'b0;
      end
      if (wact && ctr == 2'd1) whi = slice_in;
      if (ctr == 2'd0 && wr_en) begin wact = 1'b1; wlo = slice_in; end
      rxpush = 1'b0;
      if (r_act) begin
        r_c++;
        if (r_c == H && m_s2) r_act = 1'b0;
        else if (r_c > H && (r_c - H) % CD == 0) begin
          k = (r_c - H) / CD;
          if (k <= 8) r_byte[k-1] = m_s2;
          else begin rxpush = m_s2; r_act = 1'b0; end
        end
      end else if (!m_s2) begin
        r_act = 1'b1; r_c = 0;
      end
      if (ract && ctr == 2'd3) begin void'(rxq.pop_front()); ract = 1'b0; end
      else if (ctr == 2'd0 && rd_en && rxq.size() > 0) ract = 1'b1;
      if (rxpush && !rxf) rxq.push_back(r_byte);
      m_s2 = m_s1;
      m_s1 = line_n;
    end
  end
  always @(negedge clk) begin : cmp
    logic [3:0] es;
    logic [7:0] head;
    head = rxq.size() > 0 ? rxq[0] : 8'h00;
    es = (ctr == 2'd0 && rd_en && rxq.size() != 0) ? head[3:0] : (ract && ctr == 2'd1) ? head[7:4] : 4'h0;
    chk("tx_line", tx, m_t == 0 ? 1 : m_frame[(10*CD - m_t) / CD]);
    chk("tx_full", tx_full, txq.size() == DEPTH);
    chk("rx_vld", rx_vld, rxq.size() != 0);
    chk("rd_slice", slice_out, es);
  end
  task automatic step();
    @(posedge clk);
    #1 ctr = ctr + 2'd1;
  endtask
  task automatic write(input logic [7:0] b);
    while (ctr != 2'd3) step();
    step(); wr_en = 1'b1; slice_in = b[3:0];
    step(); slice_in = b[7:4];
    step(); slice_in = 4'hE;
    step(); slice_in = 4'hD;
    step(); wr_en = 1'b0; slice_in = 4'h0;
  endtask
  task automatic read(output logic [15:0] s);
    while (ctr != 2'd3) step();
    step(); rd_en = 1'b1; @(negedge clk); s[3:0] = slice_out;
    step(); @(negedge clk); s[7:4] = slice_out;
    step(); @(negedge clk); s[11:8] = slice_out;
    step(); @(negedge clk); s[15:12] = slice_out;
    step(); rd_en = 1'b0;
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CD) step();
    end
    rx_drv = 1'b1;
  endtask
  task automatic check_tx(input string name, input logic [9:0] f);
    int n;
    n = 0;
    while (tx && n < 300) begin step(); n++; end
    chk({name, "_start_seen"}, tx, 0);
    repeat (H) step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_bit%0d", name, i), tx, f[i]);
      if (i < 9) repeat (CD) step();
    end
  endtask
  task automatic wait_vld(input string name);
    int n;
    n = 0;
    while (!rx_vld && n < 400) begin step(); n++; end
    chk(name, rx_vld, 1);
  endtask
  logic [15:0] s;
  initial begin
    repeat (3) step();
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_tx_full", tx_full, 0);
    chk("reset_rx_vld", rx_vld, 0);
    chk("reset_slice", slice_out, 0);
    step(); rst_n = 1'b1;
    repeat (4) step();
    // 0xA5 on the line: start, 1,0,1,0,0,1,0,1, stop
    write(8'hA5);
    check_tx("a5", 10'b1101001010);
    repeat (20) step();
    // TX busy with 0x11, four buffered fill the FIFO, fifth is dropped
    write(8'h11);
    write(8'h21); write(8'h22); write(8'h23);
    @(negedge clk); chk("tx_full_after_3", tx_full, 0);
    write(8'h24);
    @(negedge clk); chk("tx_full_after_4", tx_full, 1);
    write(8'h25);
    @(negedge clk); chk("tx_full_after_drop", tx_full, 1);
    repeat (6 * FRAME) step();
    chk("tx_drained", tx_full, 0);
    // Read while empty returns zeros
    read(s);
    chk("empty_read", s, 16'h0000);
    send_rx(8'h3C, 1'b1);
    wait_vld("rx_3c_vld");
    read(s);
    chk("rx_3c_slices", s, 16'h003C);
    @(negedge clk); chk("rx_3c_popped", rx_vld, 0);
    rx_drv = 1'b0;
    repeat (4) step();
    rx_drv = 1'b1;
    repeat (40) step();
    chk("glitch_no_push", rx_vld, 0);
    send_rx(8'h81, 1'b0);
    repeat (40) step();
    chk("bad_stop_no_push", rx_vld, 0);
    loop = 1'b1;
    write(8'h5A); write(8'hFF); write(8'h00);
    repeat (3 * FRAME + 60) step();
    read(s); chk("loop_0", s, 16'h005A);
    read(s); chk("loop_1", s, 16'h00FF);
    read(s); chk("loop_2", s, 16'h0000);
    @(negedge clk); chk("loop_empty", rx_vld, 0);
    loop = 1'b0;
    repeat (4) step();
    send_rx(8'h77, 1'b1);
    wait_vld("pre_reset_vld");
    write(8'hC3); write(8'h01); write(8'h02); write(8'h03); write(8'h04);
    @(negedge clk); chk("pre_reset_full", tx_full, 1);
    step(); repeat (20) step();
    #3 rst_n = 1'b0;
    #1;
    chk("midframe_rst_tx", tx, 1);
    chk("midframe_rst_full", tx_full, 0);
    chk("midframe_rst_vld", rx_vld, 0);
    chk("midframe_rst_slice", slice_out, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    write(8'h96);
    check_tx("post_rst_96", 10'b1100101100);
    repeat (20) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
